// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the vALU result mux. Captures the mux result
// and its select tag, computes zero/negative/parity flags at capture time and
// hands the entry downstream through a valid/ready handshake. A main register
// plus one skid register keep in_ready registered while still sustaining one
// transfer per cycle.

module alu_result_stage #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic [SEL_WIDTH-1:0] in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_parity,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    // Entry layout: {result, sel, zero, neg, parity}
    localparam int EW = WIDTH + SEL_WIDTH + 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Odd parity indicator: 1 when the value holds an odd number of ones
    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    // Pack a result and its tag into an entry with flags computed once, here
    function automatic logic [EW-1:0] make_entry(input logic [WIDTH-1:0]     result,
                                                 input logic [SEL_WIDTH-1:0] sel);
        logic zero_flag;
        zero_flag = (result == {WIDTH{1'b0}});
        return {result, sel, zero_flag, result[WIDTH-1], calc_parity(result)};
    endfunction

    state_t               state_q, state_d;
    logic [EW-1:0]        main_q, main_d;
    logic [EW-1:0]        skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept_s;
    logic                 take_s;
    logic [EW-1:0]        in_entry_s;

    assign accept_s   = in_valid & in_ready_q;
    assign take_s     = out_valid_q & out_ready;
    assign in_entry_s = make_entry(in_result, in_sel);

    // Occupancy FSM: decides where an accepted entry lands and what moves forward
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_d  = in_entry_s;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (accept_s && take_s) begin
                    main_d  = in_entry_s;
                    state_d = ST_BUSY;
                end else if (accept_s) begin
                    // Consumer stalled: park the new entry behind the main one
                    skid_d  = in_entry_s;
                    state_d = ST_FULL;
                end else if (take_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so in_valid cannot cause an accept
                if (take_s) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs follow the next occupancy so they can be registered
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Saturating count of completed output transfers
    always_comb begin
        if (take_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, entry and counter registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= {EW{1'b0}};
            skid_q      <= {EW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_q[EW-1 -: WIDTH];
    assign out_sel    = main_q[3 +: SEL_WIDTH];
    assign out_zero   = main_q[2];
    assign out_neg    = main_q[1];
    assign out_parity = main_q[0];
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: a queue-based occupancy model with
// a per-cycle compare process, directed scenarios with literal expectations,
// and a randomized handshake phase.

module tb_alu_result_stage;

    localparam int W  = 32;
    localparam int SW = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [SW-1:0] in_sel;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [SW-1:0] out_sel;
    logic          out_zero;
    logic          out_neg;
    logic          out_parity;
    logic [CW-1:0] xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of held entries {sel, result}, front = what out_* must show
    logic [SW+W-1:0] mq[$];
    int              mcnt = 0;

    alu_result_stage #(.WIDTH(W), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_parity (out_parity),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model on every falling edge, then advance the model
    // using the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        logic [W-1:0]  r;
        logic [SW-1:0] s;
        bit            take;
        bit            acc;
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
        end
        chk("m_in_ready",  in_ready,   (mq.size() < 2) ? 64'd1 : 64'd0);
        chk("m_out_valid", out_valid,  (mq.size() > 0) ? 64'd1 : 64'd0);
        chk("m_count",     xfer_count, mcnt);
        if (mq.size() > 0) begin
            r = mq[0][W-1:0];
            s = mq[0][SW+W-1:W];
            chk("m_result", out_result, r);
            chk("m_sel",    out_sel,    s);
            chk("m_zero",   out_zero,   (r == 0) ? 64'd1 : 64'd0);
            chk("m_neg",    out_neg,    (r >= 32'h8000_0000) ? 64'd1 : 64'd0);
            chk("m_parity", out_parity, $countones(r) % 2);
        end
        if (rst_n) begin
            take = (mq.size() > 0) && out_ready;
            acc  = in_valid && (mq.size() < 2);
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back({in_sel, in_result});
            if (take && mcnt < CMAX) mcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] r, input logic [SW-1:0] s);
        in_valid  = 1'b1;
        in_result = r;
        in_sel    = s;
    endtask

    initial begin
        logic [W-1:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_out_valid", out_valid,  1'b0);
        chk("rst_in_ready",  in_ready,   1'b1);
        chk("rst_result",    out_result, 32'h0);
        chk("rst_sel",       out_sel,    4'h0);
        chk("rst_flags",     {out_zero, out_neg, out_parity}, 3'b000);
        chk("rst_count",     xfer_count, 4'h0);
        rst_n = 1'b1;
        tick();

        // T2 single pass
        out_ready = 1'b1;
        send(32'h1, 4'h0);
        tick();
        chk("t2_valid",  out_valid,  1'b1);
        chk("t2_result", out_result, 32'h1);
        chk("t2_sel",    out_sel,    4'h0);
        chk("t2_flags",  {out_zero, out_neg, out_parity}, 3'b001);

        // T3 flags
        send(32'h0, 4'h3);
        tick();
        chk("t3_zero_flags", {out_zero, out_neg, out_parity}, 3'b100);
        send(32'h8000_0003, 4'h5);
        tick();
        chk("t3_neg_result", out_result, 32'h8000_0003);
        chk("t3_neg_flags",  {out_zero, out_neg, out_parity}, 3'b011);
        in_valid = 1'b0;
        tick();
        tick();

        // T4 backpressure
        out_ready = 1'b0;
        send(32'h1, 4'h0);
        tick();
        chk("t4_ready_1st", in_ready, 1'b1);
        send(32'h2, 4'h1);
        tick();
        chk("t4_ready_full", in_ready,   1'b0);
        chk("t4_hold_res",   out_result, 32'h1);
        chk("t4_hold_sel",   out_sel,    4'h0);
        in_valid = 1'b0;
        tick();
        chk("t4_hold2_res", out_result, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("t4_second_res", out_result, 32'h2);
        chk("t4_second_sel", out_sel,    4'h1);
        chk("t4_ready_back", in_ready,   1'b1);
        tick();
        chk("t4_drained", out_valid, 1'b0);

        // T5 streaming from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v = 32'h100 + k;
            send(v, k[SW-1:0]);
            tick();
            chk("t5_in_ready", in_ready,   1'b1);
            chk("t5_result",   out_result, v);
        end
        in_valid = 1'b0;
        tick();
        chk("t5_count", xfer_count, 4'd8);
        chk("t5_empty", out_valid,  1'b0);

        // T6 saturation: 20 more takes on a 4-bit counter
        for (int k = 0; k < 20; k++) begin
            send($urandom, 4'(k));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_sat", xfer_count, 4'hF);
        tick();
        tick();
        chk("t6_sat_hold", xfer_count, 4'hF);

        // T1 asynchronous reset while FULL
        out_ready = 1'b0;
        send(32'hAAAA_0001, 4'h7);
        tick();
        send(32'hBBBB_0002, 4'h8);
        tick();
        chk("t1_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", out_valid,  1'b0);
        chk("t1_in_ready",  in_ready,   1'b1);
        chk("t1_count",     xfer_count, 4'h0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized handshake traffic, with a few bias phases
        for (int k = 0; k < 900; k++) begin
            int ph;
            ph = k / 300;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                        (ph == 1) ? ($urandom_range(0, 3) == 0) :
                                    ($urandom_range(0, 1) != 0);
            case ($urandom_range(0, 7))
                0:       in_result = 32'h0;
                1:       in_result = 32'h8000_0000;
                2:       in_result = 32'hFFFF_FFFF;
                default: in_result = $urandom;
            endcase
            in_sel = 4'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
